flex_shift_engine: RTL and testbench



---
 rtl/flex_shift_engine_if.sv | 27 ++
 rtl/flex_shift_engine.sv | 154 +++++++++++++++
 tb/tb_flex_shift_engine.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/flex_shift_engine_if.sv
// Handshake and serial/parallel bus bundle for flex_shift_engine.
// The engine uses the slave modport; the driving controller uses master.
interface flex_shift_engine_if #(
    parameter int NUM_BITS = 8
);
    logic                load_valid;
    logic                load_ready;
    logic [NUM_BITS-1:0] parallel_in;
    logic                msb_first;
    logic                shift_enable;
    logic                serial_in;
    logic                serial_out;
    logic [NUM_BITS-1:0] parallel_out;
    logic                busy;
    logic                done;
    logic                parity_err;

    modport slave (
        input  load_valid, parallel_in, msb_first, shift_enable, serial_in,
        output load_ready, serial_out, parallel_out, busy, done, parity_err
    );

    modport master (
        output load_valid, parallel_in, msb_first, shift_enable, serial_in,
        input  load_ready, serial_out, parallel_out, busy, done, parity_err
    );
endinterface

// File: rtl/flex_shift_engine.sv
// Full-duplex shift engine with per-frame bit order and a one-cycle done pulse.
// Optional even-parity bit appended to each frame when FLEX_SHIFT_PARITY_EN is defined.
module flex_shift_engine #(
    parameter int   NUM_BITS = 8,
    parameter logic IDLE_VAL = 1'b1
) (
    input logic               clk,
    input logic               n_rst,
    flex_shift_engine_if.slave bus
);
`ifdef FLEX_SHIFT_PARITY_EN
    localparam int FRAME_LEN = NUM_BITS + 1;
`else
    localparam int FRAME_LEN = NUM_BITS;
`endif
    localparam int CNT_W = $clog2(NUM_BITS + 2);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state_r;
    logic [NUM_BITS-1:0] tx_r;
    logic [NUM_BITS-1:0] rx_r;
    logic [NUM_BITS-1:0] parallel_out_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                order_r;
    logic                load_ready_r;
    logic                busy_r;
    logic                done_r;
    logic                serial_out_r;

    function automatic logic [NUM_BITS-1:0] tx_shift(input logic [NUM_BITS-1:0] t, input logic msb);
        tx_shift = msb ? {t[NUM_BITS-2:0], IDLE_VAL} : {IDLE_VAL, t[NUM_BITS-1:1]};
    endfunction

    function automatic logic [NUM_BITS-1:0] rx_shift(input logic [NUM_BITS-1:0] r, input logic msb,
                                                     input logic b);
        rx_shift = msb ? {r[NUM_BITS-2:0], b} : {b, r[NUM_BITS-1:1]};
    endfunction

    function automatic logic tx_bit(input logic [NUM_BITS-1:0] t, input logic msb);
        tx_bit = msb ? t[NUM_BITS-1] : t[0];
    endfunction

`ifdef FLEX_SHIFT_PARITY_EN
    logic par_r;
    logic parity_err_r;

    function automatic logic even_parity(input logic [NUM_BITS-1:0] w);
        even_parity = ^w;
    endfunction
`endif

    // Frame FSM; serial_out is precomputed from the next tx word so it is registered.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r        <= IDLE;
            tx_r           <= {NUM_BITS{IDLE_VAL}};
            rx_r           <= {NUM_BITS{1'b0}};
            parallel_out_r <= {NUM_BITS{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            order_r        <= 1'b1;
            load_ready_r   <= 1'b1;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            serial_out_r   <= IDLE_VAL;
`ifdef FLEX_SHIFT_PARITY_EN
            par_r          <= 1'b0;
            parity_err_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.load_valid) begin
                        state_r      <= ACTIVE;
                        load_ready_r <= 1'b0;
                        busy_r       <= 1'b1;
                        tx_r         <= bus.parallel_in;
                        order_r      <= bus.msb_first;
                        cnt_r        <= {CNT_W{1'b0}};
                        rx_r         <= {NUM_BITS{1'b0}};
                        serial_out_r <= tx_bit(bus.parallel_in, bus.msb_first);
`ifdef FLEX_SHIFT_PARITY_EN
                        par_r        <= even_parity(bus.parallel_in);
`endif
                    end else begin
                        serial_out_r <= IDLE_VAL;
                    end
                end
                ACTIVE: begin
                    if (bus.shift_enable) begin
                        tx_r  <= tx_shift(tx_r, order_r);
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef FLEX_SHIFT_PARITY_EN
                        // The trailing parity bit is checked, never stored in rx.
                        if (cnt_r < CNT_W'(NUM_BITS)) begin
                            rx_r <= rx_shift(rx_r, order_r, bus.serial_in);
                        end else begin
                            rx_r <= rx_r;
                        end
`else
                        rx_r  <= rx_shift(rx_r, order_r, bus.serial_in);
`endif
                        if (cnt_r == CNT_W'(FRAME_LEN - 1)) begin
                            state_r        <= IDLE;
                            load_ready_r   <= 1'b1;
                            busy_r         <= 1'b0;
                            done_r         <= 1'b1;
                            serial_out_r   <= IDLE_VAL;
`ifdef FLEX_SHIFT_PARITY_EN
                            parallel_out_r <= rx_r;
                            parity_err_r   <= bus.serial_in ^ even_parity(rx_r);
`else
                            parallel_out_r <= rx_shift(rx_r, order_r, bus.serial_in);
`endif
                        end else begin
`ifdef FLEX_SHIFT_PARITY_EN
                            if (cnt_r == CNT_W'(NUM_BITS - 1)) begin
                                serial_out_r <= par_r;
                            end else begin
                                serial_out_r <= tx_bit(tx_shift(tx_r, order_r), order_r);
                            end
`else
                            serial_out_r <= tx_bit(tx_shift(tx_r, order_r), order_r);
`endif
                        end
                    end else begin
                        state_r <= ACTIVE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    load_ready_r <= 1'b1;
                    busy_r       <= 1'b0;
                    serial_out_r <= IDLE_VAL;
                end
            endcase
        end
    end

    assign bus.load_ready   = load_ready_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.serial_out   = serial_out_r;
    assign bus.parallel_out = parallel_out_r;
`ifdef FLEX_SHIFT_PARITY_EN
    assign bus.parity_err   = parity_err_r;
`else
    assign bus.parity_err   = 1'b0;
`endif
endmodule

// File: tb/tb_flex_shift_engine.sv
// Directed self-checking bench for flex_shift_engine (NUM_BITS=8, IDLE_VAL=1).
// Parity scenarios run when FLEX_SHIFT_PARITY_EN is defined.
module tb_flex_shift_engine;
    logic clk;
    logic n_rst;
    logic loop_en;
    logic drv_in;
    int   total;
    int   bad;

    flex_shift_engine_if #(.NUM_BITS(8)) bus ();

    flex_shift_engine #(.NUM_BITS(8), .IDLE_VAL(1'b1)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    assign bus.serial_in = loop_en ? bus.serial_out : drv_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tick();
        tick();
        total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.load_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", bus.parity_err); end
        total++; if (bus.parallel_out !== 8'h00) begin bad++; $display("FAIL reset_pout got=%h want=00", bus.parallel_out); end
        total++; if (bus.serial_out !== 1'b1) begin bad++; $display("FAIL reset_sout got=%b want=1", bus.serial_out); end
        n_rst = 1'b1;
        tick();
    endtask

`ifndef FLEX_SHIFT_PARITY_EN
    task automatic test_msb_loopback();
        logic [7:0] seq;
        seq = 8'b1010_0101;  // first transmitted bit in [7]
        loop_en = 1'b1;
        bus.parallel_in = 8'hA5; bus.msb_first = 1'b1;
        bus.load_valid = 1'b1; bus.shift_enable = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL msb_busy got=%b want=1", bus.busy); end
        for (int i = 0; i < 8; i++) begin
            total++; if (bus.serial_out !== seq[7-i]) begin bad++; $display("FAIL msb_sout bit=%0d got=%b want=%b", i, bus.serial_out, seq[7-i]); end
            if (i > 0) begin
                total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL msb_early_done bit=%0d got=%b want=0", i, bus.done); end
            end
            tick();
        end
        bus.shift_enable = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL msb_done got=%b want=1", bus.done); end
        total++; if (bus.parallel_out !== 8'hA5) begin bad++; $display("FAIL msb_pout got=%h want=a5", bus.parallel_out); end
        total++; if (bus.serial_out !== 1'b1) begin bad++; $display("FAIL msb_idle_sout got=%b want=1", bus.serial_out); end
        total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL msb_ready got=%b want=1", bus.load_ready); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL msb_done_drop got=%b want=0", bus.done); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        logic [7:0] rxb;
        seq = 8'b0011_1100;  // expected serial_out, first bit in [7]
        rxb = 8'b1100_0000;  // serial_in stimulus, first bit in [7]
        loop_en = 1'b0;
        bus.parallel_in = 8'h3C; bus.msb_first = 1'b0;
        bus.load_valid = 1'b1; bus.shift_enable = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drv_in = rxb[7-i];
            total++; if (bus.serial_out !== seq[7-i]) begin bad++; $display("FAIL lsb_sout bit=%0d got=%b want=%b", i, bus.serial_out, seq[7-i]); end
            tick();
        end
        bus.shift_enable = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL lsb_done got=%b want=1", bus.done); end
        total++; if (bus.parallel_out !== 8'h03) begin bad++; $display("FAIL lsb_pout got=%h want=03", bus.parallel_out); end
        tick();
    endtask

    task automatic test_gaps_and_back_to_back();
        logic [7:0] seq;
        logic [7:0] rxb;
        seq = 8'b0101_1010;  // 8'h5A MSB-first
        rxb = 8'b1001_1101;  // received MSB-first -> 8'h9D
        loop_en = 1'b0;
        bus.parallel_in = 8'h5A; bus.msb_first = 1'b1;
        bus.load_valid = 1'b1; bus.shift_enable = 1'b0;
        tick();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < 4; g++) begin
                if (i == 3 && g == 1) begin
                    bus.parallel_in = 8'hFF; bus.msb_first = 1'b0; bus.load_valid = 1'b1;
                end
                tick();
                bus.load_valid = 1'b0;
            end
            if (i == 3) begin
                total++; if (bus.load_ready !== 1'b0) begin bad++; $display("FAIL gap_ready got=%b want=0", bus.load_ready); end
                total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b want=1", bus.busy); end
            end
            total++; if (bus.serial_out !== seq[7-i]) begin bad++; $display("FAIL gap_sout bit=%0d got=%b want=%b", i, bus.serial_out, seq[7-i]); end
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL gap_early_done bit=%0d got=%b want=0", i, bus.done); end
            drv_in = rxb[7-i];
            bus.shift_enable = 1'b1;
            tick();
            bus.shift_enable = 1'b0;
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL gap_done got=%b want=1", bus.done); end
        total++; if (bus.parallel_out !== 8'h9D) begin bad++; $display("FAIL gap_pout got=%h want=9d", bus.parallel_out); end
        // new load in the done cycle, strobe held high, looped back
        loop_en = 1'b1;
        bus.parallel_in = 8'h0E; bus.msb_first = 1'b0;
        bus.load_valid = 1'b1; bus.shift_enable = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", bus.busy); end
        total++; if (bus.serial_out !== 1'b0) begin bad++; $display("FAIL b2b_sout got=%b want=0", bus.serial_out); end
        for (int i = 0; i < 8; i++) tick();
        bus.shift_enable = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", bus.done); end
        total++; if (bus.parallel_out !== 8'h0E) begin bad++; $display("FAIL b2b_pout got=%h want=0e", bus.parallel_out); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        loop_en = 1'b1;
        bus.parallel_in = 8'h00; bus.msb_first = 1'b1;
        bus.load_valid = 1'b1; bus.shift_enable = 1'b0;
        tick();
        bus.load_valid = 1'b0;
        bus.shift_enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++; if (bus.serial_out !== 1'b0) begin bad++; $display("FAIL mid_sout_pre got=%b want=0", bus.serial_out); end
        n_rst = 1'b0;
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", bus.done); end
        total++; if (bus.parallel_out !== 8'h00) begin bad++; $display("FAIL mid_pout got=%h want=00", bus.parallel_out); end
        total++; if (bus.serial_out !== 1'b1) begin bad++; $display("FAIL mid_sout got=%b want=1", bus.serial_out); end
        total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", bus.load_ready); end
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mid_no_done cyc=%0d got=%b want=0", i, bus.done); end
        end
        bus.shift_enable = 1'b0;
    endtask
`else
    task automatic run_parity_frame(input logic [7:0] word, input logic force_par, input logic par_bit,
                                    input logic want_err, input logic want_prev_err, input string tag);
        loop_en = 1'b1;
        bus.parallel_in = word; bus.msb_first = 1'b1;
        bus.load_valid = 1'b1; bus.shift_enable = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        total++; if (bus.serial_out !== 1'b1) begin bad++; $display("FAIL %s_par_bit got=%b want=1", tag, bus.serial_out); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_early_done got=%b want=0", tag, bus.done); end
        total++; if (bus.parity_err !== want_prev_err) begin bad++; $display("FAIL %s_perr_hold got=%b want=%b", tag, bus.parity_err, want_prev_err); end
        if (force_par) begin
            loop_en = 1'b0;
            drv_in = par_bit;
        end
        tick();
        bus.shift_enable = 1'b0;
        loop_en = 1'b1;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL %s_done got=%b want=1", tag, bus.done); end
        total++; if (bus.parallel_out !== word) begin bad++; $display("FAIL %s_pout got=%h want=%h", tag, bus.parallel_out, word); end
        total++; if (bus.parity_err !== want_err) begin bad++; $display("FAIL %s_perr got=%b want=%b", tag, bus.parity_err, want_err); end
        for (int i = 0; i < 3; i++) tick();
        total++; if (bus.parity_err !== want_err) begin bad++; $display("FAIL %s_perr_idle got=%b want=%b", tag, bus.parity_err, want_err); end
    endtask

    task automatic test_parity();
        run_parity_frame(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, "par_good");
        run_parity_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, "par_bad");
        run_parity_frame(8'h07, 1'b0, 1'b0, 1'b0, 1'b1, "par_clear");
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        n_rst = 1'b0;
        loop_en = 1'b0;
        drv_in = 1'b0;
        bus.load_valid = 1'b0;
        bus.parallel_in = 8'h00;
        bus.msb_first = 1'b1;
        bus.shift_enable = 1'b0;
        test_reset();
`ifndef FLEX_SHIFT_PARITY_EN
        test_msb_loopback();
        test_lsb_first();
        test_gaps_and_back_to_back();
        test_reset_mid_frame();
`else
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
